// File: rtl/instr_cache_mt_core_if.sv
// Fetch-side lookup and memory-side refill signals of the multithreaded instruction cache.
// slave = cache side; master = the fetch unit / memory hierarchy side.
interface instr_cache_mt_core_if #(
  parameter int THR_PER_CORE = 2,
  parameter int LINE_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 20,
  parameter int TID_W        = (THR_PER_CORE > 1) ? $clog2(THR_PER_CORE) : 1
);
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [TID_W-1:0]        req_thread_id;
  logic                    rsp_valid;
  logic [LINE_WIDTH-1:0]   rsp_data;
  logic [THR_PER_CORE-1:0] icache_ready;
  logic                    req_valid_miss;
  logic [ADDR_WIDTH-1:0]   req_addr_miss;
  logic [TID_W-1:0]        req_thread_id_miss;
  logic                    rsp_valid_miss;
  logic [TID_W-1:0]        rsp_thread_id;
  logic [LINE_WIDTH-1:0]   rsp_data_miss;
  logic                    rsp_bus_error;
  logic                    xcpt_bus_error;

  modport slave (
    input  req_valid, req_addr, req_thread_id,
    input  rsp_valid_miss, rsp_thread_id, rsp_data_miss, rsp_bus_error,
    output rsp_valid, rsp_data, icache_ready,
    output req_valid_miss, req_addr_miss, req_thread_id_miss, xcpt_bus_error
  );

  modport master (
    output req_valid, req_addr, req_thread_id,
    output rsp_valid_miss, rsp_thread_id, rsp_data_miss, rsp_bus_error,
    input  rsp_valid, rsp_data, icache_ready,
    input  req_valid_miss, req_addr_miss, req_thread_id_miss, xcpt_bus_error
  );
endinterface

// File: rtl/instr_cache_mt_core.sv
// Direct-mapped read-only multithreaded icache: 0-cycle hit, one outstanding refill per thread.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module instr_cache_mt_core #(
  parameter int THR_PER_CORE = 2,
  parameter int NUM_LINES    = 4,
  parameter int LINE_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 20,
  parameter int TID_W        = (THR_PER_CORE > 1) ? $clog2(THR_PER_CORE) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic mt_mode,
`ifdef ICACHE_STATS_EN
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
`endif
  instr_cache_mt_core_if.slave bus
);
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TSUB  = $clog2(THR_PER_CORE);
  localparam int TAG_W = ADDR_WIDTH - OFS - IDX_W;

  logic [NUM_LINES-1:0]    line_vld;
  logic [TAG_W-1:0]        line_tag [NUM_LINES];
  logic [LINE_WIDTH-1:0]   line_dat [NUM_LINES];
  logic [THR_PER_CORE-1:0] pend;
  logic [ADDR_WIDTH-1:0]   pend_addr [THR_PER_CORE];

  logic [IDX_W-1:0]      lk_idx, fill_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  lk_ok, hit, miss, fill_act, fill_ok;

  // In partitioned mode the top index bits select the thread's private slice of lines.
  function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [TID_W-1:0] t, input logic mt);
    logic [IDX_W-1:0] r;
    r = a[OFS +: IDX_W];
    if (mt) begin
      for (int i = 0; i < TSUB; i++) r[IDX_W-TSUB+i] = t[i];
    end
    return r;
  endfunction

  always_comb begin
    lk_idx    = line_idx(bus.req_addr, bus.req_thread_id, mt_mode);
    lk_tag    = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
    lk_ok     = bus.req_valid & ~pend[bus.req_thread_id];
    hit       = lk_ok & line_vld[lk_idx] & (line_tag[lk_idx] == lk_tag);
    miss      = lk_ok & ~hit;
    fill_act  = bus.rsp_valid_miss & pend[bus.rsp_thread_id];
    fill_ok   = fill_act & ~bus.rsp_bus_error;
    fill_addr = pend_addr[bus.rsp_thread_id];
    fill_idx  = line_idx(fill_addr, bus.rsp_thread_id, mt_mode);
  end

  assign bus.rsp_valid      = hit;
  assign bus.rsp_data       = line_dat[lk_idx];
  assign bus.icache_ready   = ~pend;
  assign bus.xcpt_bus_error = fill_act & bus.rsp_bus_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_vld               <= '0;
      pend                   <= '0;
      bus.req_valid_miss     <= 1'b0;
      bus.req_addr_miss      <= '0;
      bus.req_thread_id_miss <= '0;
      for (int t = 0; t < THR_PER_CORE; t++) pend_addr[t] <= '0;
    end else begin
      if (fill_ok) line_vld[fill_idx] <= 1'b1;
      // A thread cannot both miss and be refilled in one cycle: a miss needs pend clear.
      if (fill_act) pend[bus.rsp_thread_id] <= 1'b0;
      if (miss) begin
        pend[bus.req_thread_id]      <= 1'b1;
        pend_addr[bus.req_thread_id] <= {bus.req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
        bus.req_addr_miss            <= {bus.req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
        bus.req_thread_id_miss       <= bus.req_thread_id;
      end
      bus.req_valid_miss <= miss;
    end
  end

  // Line payload is qualified by line_vld, so it needs no reset.
  always_ff @(posedge clock) begin
    if (fill_ok) begin
      line_dat[fill_idx] <= bus.rsp_data_miss;
      line_tag[fill_idx] <= fill_addr[ADDR_WIDTH-1 -: TAG_W];
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hit)  stat_hits   <= stat_hits + 32'd1;
      if (miss) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_cache_mt_core.sv
// Directed, table-driven bench for instr_cache_mt_core (default configuration).
module tb_instr_cache_mt_core;
  logic clock;
  logic reset;
  logic mt_mode;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  instr_cache_mt_core_if #(.THR_PER_CORE(2), .LINE_WIDTH(128), .ADDR_WIDTH(20)) bus();

  instr_cache_mt_core #(.THR_PER_CORE(2), .NUM_LINES(4), .LINE_WIDTH(128), .ADDR_WIDTH(20)) dut (
    .clock(clock),
    .reset(reset),
    .mt_mode(mt_mode),
`ifdef ICACHE_STATS_EN
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
`endif
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic         mt;
    logic         vld;
    logic [19:0]  addr;
    logic         tid;
    logic         fv;
    logic         ftid;
    logic [127:0] fdat;
    logic         ferr;
    logic         e_rsp;
    logic [127:0] e_dat;
    logic [1:0]   e_rdy;
    logic         e_mv;
    logic [19:0]  e_maddr;
    logic         e_mtid;
    logic         e_xc;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] D1 = 128'hDEAD0000_00000000_00000000_0000BEEF;
  localparam logic [127:0] D2 = 128'h22222222_00000000_00000000_22222222;
  localparam logic [127:0] D3 = 128'h33333333_00000000_00000000_33333333;
  localparam logic [127:0] D4 = 128'h44444444_00000000_00000000_44444444;
  localparam logic [127:0] D5 = 128'h55555555_00000000_00000000_55555555;
  localparam logic [127:0] D6 = 128'h66666666_00000000_00000000_66666666;
  localparam logic [127:0] D7 = 128'h77777777_00000000_00000000_77777777;
  localparam logic [127:0] Z  = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic mt, logic vld, logic [19:0] a, logic t,
                              logic fv, logic ft, logic [127:0] fd, logic fe,
                              logic er, logic [127:0] ed, logic [1:0] erdy,
                              logic emv, logic [19:0] ema, logic emt, logic exc);
    vec_t v;
    v.name = nm; v.mt = mt; v.vld = vld; v.addr = a; v.tid = t;
    v.fv = fv; v.ftid = ft; v.fdat = fd; v.ferr = fe;
    v.e_rsp = er; v.e_dat = ed; v.e_rdy = erdy;
    v.e_mv = emv; v.e_maddr = ema; v.e_mtid = emt; v.e_xc = exc;
    return v;
  endfunction

  task automatic drive_idle();
    bus.req_valid = 0; bus.req_addr = '0; bus.req_thread_id = 0;
    bus.rsp_valid_miss = 0; bus.rsp_thread_id = 0; bus.rsp_data_miss = '0; bus.rsp_bus_error = 0;
  endtask

  initial begin
    //               name        mt vld addr      t  fv ft data ferr  rsp dat  rdy    mv maddr   mt xc
    vecs.push_back(mk("cold_miss", 0, 1, 20'h00104, 0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("miss_req0", 0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b10, 1, 20'h00100,0, 0));
    vecs.push_back(mk("fill0",     0, 0, 20'h0,     0, 1, 0, D1, 0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ready0",    0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("hit0",      0, 1, 20'h00108, 0, 0, 0, Z,  0,   1, D1, 2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("be_miss",   0, 1, 20'h00200, 1, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("be_req",    0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b01, 1, 20'h00200,1, 0));
    vecs.push_back(mk("be_rsp",    0, 0, 20'h0,     0, 1, 1, D7, 1,   0, Z,  2'b01, 0, 20'h0,   0, 1));
    vecs.push_back(mk("be_ready",  0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("be_again",  0, 1, 20'h00200, 1, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("be_req2",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b01, 1, 20'h00200,1, 0));
    vecs.push_back(mk("be_rsp2",   0, 0, 20'h0,     0, 1, 1, Z,  1,   0, Z,  2'b01, 0, 20'h0,   0, 1));
    vecs.push_back(mk("be_ready2", 0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_miss0",  0, 1, 20'h00000, 0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_miss1",  0, 1, 20'h00400, 1, 0, 0, Z,  0,   0, Z,  2'b10, 1, 20'h00000,0, 0));
    vecs.push_back(mk("ov_both",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b00, 1, 20'h00400,1, 0));
    vecs.push_back(mk("ov_fill1",  0, 0, 20'h0,     0, 1, 1, D2, 0,   0, Z,  2'b00, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_rdy1",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_hit1",   0, 1, 20'h00400, 1, 0, 0, Z,  0,   1, D2, 2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_fill0",  0, 0, 20'h0,     0, 1, 0, D3, 0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_rdy0",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_hit0",   0, 1, 20'h00000, 0, 0, 0, Z,  0,   1, D3, 2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_evict1", 0, 1, 20'h00400, 1, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_req1",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b01, 1, 20'h00400,1, 0));
    vecs.push_back(mk("ov_refill1",0, 0, 20'h0,     0, 1, 1, D2, 0,   0, Z,  2'b01, 0, 20'h0,   0, 0));
    vecs.push_back(mk("ov_rdy",    0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_miss0",  1, 1, 20'h00000, 0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_req0",   1, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b10, 1, 20'h00000,0, 0));
    vecs.push_back(mk("mt_fill0",  1, 0, 20'h0,     0, 1, 0, D4, 0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_miss1",  1, 1, 20'h00000, 1, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_req1",   1, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b01, 1, 20'h00000,1, 0));
    vecs.push_back(mk("mt_fill1",  1, 0, 20'h0,     0, 1, 1, D5, 0,   0, Z,  2'b01, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_rdy",    1, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_hit0",   1, 1, 20'h00000, 0, 0, 0, Z,  0,   1, D4, 2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("mt_hit1",   1, 1, 20'h00000, 1, 0, 0, Z,  0,   1, D5, 2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("sh_hit0",   0, 1, 20'h00000, 0, 0, 0, Z,  0,   1, D4, 2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("sh_miss1",  0, 1, 20'h00040, 1, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("sh_req1",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b01, 1, 20'h00040,1, 0));
    vecs.push_back(mk("sh_fill1",  0, 0, 20'h0,     0, 1, 1, D6, 0,   0, Z,  2'b01, 0, 20'h0,   0, 0));
    vecs.push_back(mk("sh_rdy",    0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("sh_evicted",0, 1, 20'h00000, 0, 0, 0, Z,  0,   0, Z,  2'b11, 0, 20'h0,   0, 0));
    vecs.push_back(mk("sh_req0",   0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b10, 1, 20'h00000,0, 0));
    vecs.push_back(mk("gate_req0", 0, 1, 20'h00040, 0, 0, 0, Z,  0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("gate_nomiss",0,0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("stray_rsp1",0, 0, 20'h0,     0, 1, 1, D7, 0,   0, Z,  2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("stray_hit1",0, 1, 20'h00040, 1, 0, 0, Z,  0,   1, D6, 2'b10, 0, 20'h0,   0, 0));
    vecs.push_back(mk("stray_none",0, 0, 20'h0,     0, 0, 0, Z,  0,   0, Z,  2'b10, 0, 20'h0,   0, 0));

    // Reset state
    reset = 1'b0;
    mt_mode = 1'b0;
    drive_idle();
    repeat (2) @(posedge clock);
    #4;
    check("rst_ready", 128'(bus.icache_ready), 128'(2'b11));
    check("rst_req_valid_miss", 128'(bus.req_valid_miss), 128'(1'b0));
    check("rst_req_addr_miss", 128'(bus.req_addr_miss), 128'(20'h0));
    check("rst_req_tid_miss", 128'(bus.req_thread_id_miss), 128'(1'b0));
    check("rst_xcpt", 128'(bus.xcpt_bus_error), 128'(1'b0));
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
    @(posedge clock);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      mt_mode            = vecs[i].mt;
      bus.req_valid      = vecs[i].vld;
      bus.req_addr       = vecs[i].addr;
      bus.req_thread_id  = vecs[i].tid;
      bus.rsp_valid_miss = vecs[i].fv;
      bus.rsp_thread_id  = vecs[i].ftid;
      bus.rsp_data_miss  = vecs[i].fdat;
      bus.rsp_bus_error  = vecs[i].ferr;
      #3;
      check({vecs[i].name, ".rsp_valid"}, 128'(bus.rsp_valid), 128'(vecs[i].e_rsp));
      if (vecs[i].e_rsp) check({vecs[i].name, ".rsp_data"}, bus.rsp_data, vecs[i].e_dat);
      check({vecs[i].name, ".ready"}, 128'(bus.icache_ready), 128'(vecs[i].e_rdy));
      check({vecs[i].name, ".req_valid_miss"}, 128'(bus.req_valid_miss), 128'(vecs[i].e_mv));
      if (vecs[i].e_mv) begin
        check({vecs[i].name, ".req_addr_miss"}, 128'(bus.req_addr_miss), 128'(vecs[i].e_maddr));
        check({vecs[i].name, ".req_tid_miss"}, 128'(bus.req_thread_id_miss), 128'(vecs[i].e_mtid));
      end
      check({vecs[i].name, ".xcpt"}, 128'(bus.xcpt_bus_error), 128'(vecs[i].e_xc));
    end

    // Thread 0 still has a refill outstanding; assert reset mid-cycle.
    @(posedge clock);
    #1 drive_idle();
    #2 reset = 1'b0;
    #1;
    check("amid_ready", 128'(bus.icache_ready), 128'(2'b11));
    check("amid_req_valid_miss", 128'(bus.req_valid_miss), 128'(1'b0));
    #1 reset = 1'b1;
    // Late response for the flushed miss must be ignored.
    @(posedge clock);
    #1;
    bus.rsp_valid_miss = 1; bus.rsp_thread_id = 0; bus.rsp_data_miss = D7;
    #3;
    check("late_rsp_xcpt", 128'(bus.xcpt_bus_error), 128'(1'b0));
    @(posedge clock);
    #1 drive_idle();
    bus.req_valid = 1; bus.req_addr = 20'h00040; bus.req_thread_id = 1;
    #3;
    check("post_rst_ready", 128'(bus.icache_ready), 128'(2'b11));
    check("post_rst_valid_clr", 128'(bus.rsp_valid), 128'(1'b0));
    @(posedge clock);
    #1 drive_idle();
    bus.req_valid = 1; bus.req_addr = 20'h00000; bus.req_thread_id = 0;
    #3;
    check("post_rst_late_ignored", 128'(bus.rsp_valid), 128'(1'b0));
    check("post_rst_miss_strobe", 128'(bus.req_valid_miss), 128'(1'b1));
    check("post_rst_miss_addr", 128'(bus.req_addr_miss), 128'(20'h00040));
    check("post_rst_ready2", 128'(bus.icache_ready), 128'(2'b01));
    @(posedge clock);
    #1 drive_idle();
    #3;
    check("post_rst_both_pend", 128'(bus.icache_ready), 128'(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
